// File: rtl/fpu16_pkg.sv
// fpu16_pkg: shared FSM states, binary16 constants and OFUF status codes.
package fpu16_pkg;
   typedef enum logic [2:0] {IDLE, SQUARE, DIVIDE, PACK, DONE} state_t;
   localparam int FP16_BIAS = 15;
   localparam logic [15:0] FP16_POS_INF = 16'h7C00;
   localparam logic [15:0] FP16_QNAN = 16'h7E00;
   localparam logic [1:0] OFUF_NONE = 2'b00;
   localparam logic [1:0] OFUF_UF = 2'b01;
   localparam logic [1:0] OFUF_OF = 2'b10;
endpackage

// File: rtl/fp16_mant_div.sv
// fp16_mant_div: restoring divider computing 1.0/divisor, one quotient bit per cycle.
// The divisor lies in [1,2) with 1.0 = 2^(W-1); the remainder is kept for rounding.
module fp16_mant_div #(
   parameter int STEPS = 11,
   parameter int W = 22
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [W-1:0]     divisor,
   output logic             busy,
   output logic [STEPS-1:0] quotient,
   output logic [W:0]       remainder
);
   localparam int CW = $clog2(STEPS + 1);
   logic [W-1:0] d;
   logic [CW-1:0] cnt;
   logic [W:0] twice;
   logic ge;
   assign twice = {remainder[W-1:0], 1'b0};
   assign ge = twice >= {1'b0, d};
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d <= '0;
         cnt <= '0;
         busy <= 1'b0;
         quotient <= '0;
         remainder <= '0;
      end else if (start) begin
         d <= divisor;
         cnt <= CW'(STEPS);
         busy <= 1'b1;
         quotient <= '0;
         remainder <= {2'b01, {(W-1){1'b0}}};
      end else if (busy) begin
         remainder <= ge ? twice - {1'b0, d} : twice;
         quotient <= {quotient[STEPS-2:0], ge};
         cnt <= cnt - CW'(1);
         busy <= cnt != CW'(1);
      end
   end
endmodule

// File: rtl/inv_square_fp16.sv
// inv_square_fp16: multicycle binary16 1/(Y*Y) (IDLE, SQUARE, DIVIDE, PACK, DONE).
// Define INV_SQUARE_RNE_EN for round-to-nearest-even with a 12-step divide; default truncates.
module inv_square_fp16
   import fpu16_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] Yin,
   output logic [15:0] result,
   output logic        done,
   output logic [1:0]  OFUF
);
`ifdef INV_SQUARE_RNE_EN
   localparam int DIV_STEPS = 12;
`else
   localparam int DIV_STEPS = 11;
`endif
   state_t state, state_n;
   logic [14:0] y;
   logic special, pack_wait, unity, accept, special_in, div_busy, carry;
   logic signed [7:0] e2, e2_sq, exp_b;
   logic [3:0] step;
   logic [10:0] sig;
   logic [21:0] prod, m_norm;
   logic [DIV_STEPS-1:0] quo;
   logic [22:0] rem;
   logic [9:0] frac;
   logic [15:0] pack_res;
   logic [1:0] pack_of;

   assign sig = {1'b1, y[9:0]};
   assign prod = sig * sig;
   assign m_norm = prod[21] ? prod : {prod[20:0], 1'b0};
   assign e2_sq = $signed({2'b00, y[14:10], prod[21]}) - $signed(8'(2 * FP16_BIAS));
   assign accept = (state == IDLE || state == DONE) && start;
   assign special_in = Yin[14:10] == 5'd0 || Yin[14:10] == 5'd31;
   assign done = state == DONE;

   fp16_mant_div #(.STEPS(DIV_STEPS), .W(22)) u_div (
      .clk(clk),
      .reset(reset),
      .start(state == SQUARE),
      .divisor(m_norm),
      .busy(div_busy),
      .quotient(quo),
      .remainder(rem)
   );

   // quotient MSB is the implicit leading one; the exactly-1.0 square bypasses it
`ifdef INV_SQUARE_RNE_EN
   logic [10:0] frac_sum;
   logic quo_unused;
   assign frac_sum = {1'b0, quo[10:1]} + {10'd0, quo[0] & ((|rem) | quo[1])};
   assign carry = frac_sum[10] & ~unity;
   assign frac = unity ? 10'd0 : frac_sum[9:0];
   assign quo_unused = quo[11];
`else
   logic div_unused;
   assign div_unused = ^{quo[10], rem};
   assign carry = 1'b0;
   assign frac = unity ? 10'd0 : quo[9:0];
`endif
   assign exp_b = $signed(8'(FP16_BIAS)) - (unity ? 8'sd0 : 8'sd1) - e2 + $signed({7'd0, carry});

   always_comb begin
      pack_res = {1'b0, exp_b[4:0], frac};
      pack_of = OFUF_NONE;
      if (special) begin
         pack_res = y[14:10] == 5'd0 ? FP16_POS_INF : y[9:0] == 10'd0 ? 16'h0000 : FP16_QNAN;
         pack_of = y[14:10] == 5'd0 ? OFUF_OF : y[9:0] == 10'd0 ? OFUF_UF : OFUF_NONE;
      end else if (exp_b >= 8'sd31) begin
         pack_res = FP16_POS_INF;
         pack_of = OFUF_OF;
      end else if (exp_b <= 8'sd0) begin
         pack_res = 16'h0000;
         pack_of = OFUF_UF;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE, DONE: if (start) state_n = special_in ? PACK : SQUARE;
         SQUARE:     state_n = DIVIDE;
         DIVIDE:     if (div_busy && step == 4'(DIV_STEPS - 1)) state_n = PACK;
         PACK:       if (!pack_wait) state_n = DONE;
         default:    state_n = IDLE;
      endcase
   end

   // special operands spend two cycles in PACK: classify, then commit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         y <= '0;
         special <= 1'b0;
         pack_wait <= 1'b0;
         e2 <= '0;
         unity <= 1'b0;
         step <= '0;
         result <= 16'h0000;
         OFUF <= OFUF_NONE;
      end else begin
         state <= state_n;
         if (accept) begin
            y <= Yin[14:0];
            special <= special_in;
            pack_wait <= special_in;
         end else if (state == PACK) begin
            pack_wait <= 1'b0;
         end
         if (state == SQUARE) begin
            e2 <= e2_sq;
            unity <= prod == 22'h100000;
         end
         step <= state == DIVIDE ? step + 4'd1 : 4'd0;
         if (state == PACK && !pack_wait) begin
            result <= pack_res;
            OFUF <= pack_of;
         end
      end
   end
endmodule

// File: tb/tb_inv_square_fp16.sv
// tb_inv_square_fp16: random and directed checks of inv_square_fp16 against an
// exact-integer model of 1/(Y*Y); honours INV_SQUARE_RNE_EN like the design.
module tb_inv_square_fp16;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic [15:0] Yin = 16'h0000;
   logic [15:0] result;
   logic done;
   logic [1:0] OFUF;
   int compared = 0;
   int mismatched = 0;
   logic exp_valid = 1'b0;
   logic [15:0] exp_res = 16'h0000;
   logic [1:0] exp_of = 2'b00;
`ifdef INV_SQUARE_RNE_EN
   localparam int NLAT = 14;
`else
   localparam int NLAT = 13;
`endif

   inv_square_fp16 dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .Yin(Yin),
      .result(result),
      .done(done),
      .OFUF(OFUF)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      compared++;
      if (act !== want) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   // returns {OFUF, result} from the exact value 2^(-2(e-15)) * 2^20 / sig^2
   function automatic logic [17:0] model(input logic [15:0] yv);
      int e, l, x, be;
      longint s, p, q, n, mm;
      bit up;
      e = int'(yv[14:10]);
      if (e == 0) return {2'b10, 16'h7C00};
      if (e == 31) return yv[9:0] == 10'd0 ? {2'b01, 16'h0000} : {2'b00, 16'h7E00};
      s = 1024 + longint'(yv[9:0]);
      p = s * s;
      q = (longint'(1) << 53) / p;
      l = 0;
      for (int i = 0; i < 64; i++) if (q[i]) l = i;
      x = (l - 33) - 2 * (e - 15);
`ifdef INV_SQUARE_RNE_EN
      n = longint'(1) << (64 - l);
      q = n / p;
      up = q[0] && ((n % p) != 0 || q[1]);
      mm = (q >> 1) + (up ? 1 : 0);
      if (mm == 2048) begin
         mm = 1024;
         x++;
      end
`else
      n = longint'(1) << (63 - l);
      mm = n / p;
`endif
      be = x + 15;
      if (be >= 31) return {2'b10, 16'h7C00};
      if (be <= 0) return {2'b01, 16'h0000};
      return {2'b00, 1'b0, 5'(be), mm[9:0]};
   endfunction

   always @(negedge clk) begin
      if (exp_valid && done) begin
         check("mon_result", {16'd0, result}, {16'd0, exp_res});
         check("mon_ofuf", {30'd0, OFUF}, {30'd0, exp_of});
      end
   end

   task automatic run_op(input logic [15:0] yv, input bit noisy);
      logic [17:0] m;
      int n;
      bit seen, sp;
      m = model(yv);
      sp = yv[14:10] == 5'd0 || yv[14:10] == 5'd31;
      @(negedge clk);
      Yin = yv;
      start = 1'b1;
      @(posedge clk);
      #1;
      check("done_drop", {31'd0, done}, 32'd0);
      exp_res = m[15:0];
      exp_of = m[17:16];
      exp_valid = 1'b1;
      start = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         if (noisy) begin
            Yin = 16'($urandom);
            start = 1'($urandom_range(0, 1));
         end
         @(posedge clk);
         #1;
         n++;
         seen = done;
      end
      start = 1'b0;
      check("latency", n, sp ? 2 : NLAT);
   endtask

   logic [15:0] lit_y [10] = '{16'h3C00, 16'h4000, 16'h3800, 16'hC000, 16'h0400,
                               16'h7800, 16'h5C00, 16'h0000, 16'h7C00, 16'h7E01};
   logic [15:0] lit_r [10] = '{16'h3C00, 16'h3400, 16'h4400, 16'h3400, 16'h7C00,
                               16'h0000, 16'h0000, 16'h7C00, 16'h0000, 16'h7E00};
   logic [1:0] lit_o [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10,
                              2'b01, 2'b01, 2'b10, 2'b01, 2'b00};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      logic [15:0] yr;
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", {16'd0, result}, 32'd0);
      check("rst_ofuf", {30'd0, OFUF}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_op(lit_y[i], i % 2 == 1);
         check("lit_result", {16'd0, result}, {16'd0, lit_r[i]});
         check("lit_ofuf", {30'd0, OFUF}, {30'd0, lit_o[i]});
         repeat (2) @(negedge clk);
      end
      run_op(16'h3133, 1'b1);
      check("r3133_exp", {27'd0, result[14:10]}, 32'd20);
      check("r3133_ulp", {31'd0, result >= 16'h50BA && result <= 16'h50BC}, 32'd1);

      for (int i = 0; i < 120; i++) begin
         yr = 16'($urandom);
         if (i % 4 != 0) yr[14:10] = 5'($urandom_range(4, 26));
         run_op(yr, i % 3 == 0);
      end

      @(negedge clk);
      Yin = 16'h4000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      exp_valid = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_result", {16'd0, result}, 32'd0);
      check("abort_ofuf", {30'd0, OFUF}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      n = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) n++;
      end
      check("no_done_after_abort", n, 0);

      @(negedge clk);
      reset = 1'b0;
      Yin = 16'h4000;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      exp_res = 16'h3400;
      exp_of = 2'b00;
      exp_valid = 1'b1;
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("release_latency", n, NLAT);
      check("release_result", {16'd0, result}, 32'h3400);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
